// File: rtl/fp_accum_stream_pkg.sv
// ---------------------------------------------------------------------------
// fp_accum_stream_pkg
// Shared definitions for the FP32 product accumulator:
//   - FP32 constants (zero, one, canonical quiet NaN)
//   - accumulator state encoding
//   - leading-zero counter used by the FP32 adder normaliser
// ---------------------------------------------------------------------------
package fp_accum_stream_pkg;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Number of leading zeros in a 27-bit significand (27 when all zero).
   // Scanning from LSB to MSB lets the highest set bit win.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_accum_stream_if.sv
// ---------------------------------------------------------------------------
// fp_accum_stream_if
// Stream bundle between a product source and the accumulator.
//   clear     : synchronous abort of the current group
//   bias      : FP32 bias, taken with the first product of a group
//   valid_in  : data_in carries a valid product
//   data_in   : FP32 product
//   sum_out   : FP32 group result, held between pulses
//   valid_out : one-cycle result strobe
//   busy      : a group is partially accumulated
// master = product source / consumer of results, slave = accumulator.
// ---------------------------------------------------------------------------
interface fp_accum_stream_if;

   logic        clear;
   logic [31:0] bias;
   logic        valid_in;
   logic [31:0] data_in;
   logic [31:0] sum_out;
   logic        valid_out;
   logic        busy;

   modport master (
      output clear, bias, valid_in, data_in,
      input  sum_out, valid_out, busy
   );

   modport slave (
      input  clear, bias, valid_in, data_in,
      output sum_out, valid_out, busy
   );

endinterface

// File: rtl/fp_accum_stream_fp_add32.sv
// ---------------------------------------------------------------------------
// fp_add32
// Combinational IEEE-754 single-precision adder.
//   sum : a + b, round-to-nearest-even
//   a   : FP32 operand
//   b   : FP32 operand
// Denormal inputs are treated as zero and denormal results flush to zero.
// +0 + -0 = +0; exact cancellation gives +0. No exception flags.
// Inf/NaN inputs propagate (inf - inf and any NaN give a quiet NaN).
// ---------------------------------------------------------------------------
module fp_add32
   import fp_accum_stream_pkg::*;
(
   output logic [31:0] sum,
   input  logic [31:0] a,
   input  logic [31:0] b
);

   logic               sa, sb;
   logic [7:0]         ea, eb;
   logic [22:0]        ma, mb;
   logic               a_zero, b_zero, a_spec, b_spec, is_nan;

   logic               swap;
   logic               big_s, small_s;
   logic [7:0]         big_e, small_e;
   logic [22:0]        big_m, small_m;
   logic [7:0]         diff;
   logic [4:0]         shamt;
   logic [53:0]        small_ext;
   logic [26:0]        big_sig, small_sig;
   logic               eff_sub;
   logic [27:0]        raw;
   logic [26:0]        norm;
   logic [4:0]         lz;
   logic signed [9:0]  exp_n;
   logic signed [9:0]  exp_r;
   logic               rnd_up;
   logic [24:0]        mant_r;
   logic [22:0]        frac;
   logic [31:0]        main_res;

   always_comb begin
      sa = a[31];  ea = a[30:23];  ma = a[22:0];
      sb = b[31];  eb = b[30:23];  mb = b[22:0];

      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_spec = (ea == 8'hFF);
      b_spec = (eb == 8'hFF);
      is_nan = (a_spec && (ma != 23'd0)) || (b_spec && (mb != 23'd0)) ||
               (a_spec && b_spec && (sa != sb));

      // Order operands by magnitude so the subtraction never goes negative.
      swap    = ({ea, ma} < {eb, mb});
      big_s   = swap ? sb : sa;
      big_e   = swap ? eb : ea;
      big_m   = swap ? mb : ma;
      small_s = swap ? sa : sb;
      small_e = swap ? ea : eb;
      small_m = swap ? ma : mb;

      // Alignment: 3 extra bits (guard, round, sticky). Shifts beyond 27 leave
      // only the sticky bit, so the shift amount is clamped there.
      diff      = big_e - small_e;
      shamt     = (diff > 8'd27) ? 5'd27 : diff[4:0];
      small_ext = {1'b1, small_m, 3'b000, 27'd0} >> shamt;
      small_sig = small_ext[53:27] | {26'd0, |small_ext[26:0]};
      big_sig   = {1'b1, big_m, 3'b000};

      eff_sub = big_s ^ small_s;
      lz      = 5'd0;
      if (!eff_sub) begin
         raw = {1'b0, big_sig} + {1'b0, small_sig};
         if (raw[27]) begin
            // Carry out: shift right one, folding the lost bit into sticky.
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = $signed({2'b00, big_e}) + 10'sd1;
         end else begin
            norm  = raw[26:0];
            exp_n = $signed({2'b00, big_e});
         end
      end else begin
         raw   = {1'b0, big_sig - small_sig};
         lz    = lzc27(raw[26:0]);
         // Large left shifts only happen when the exponents differ by <= 1,
         // in which case the difference is exact and no sticky is lost.
         norm  = raw[26:0] << lz;
         exp_n = $signed({2'b00, big_e}) - $signed({5'd0, lz});
      end

      // Round to nearest, ties to even.
      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
      exp_r  = exp_n + $signed({9'd0, mant_r[24]});
      frac   = mant_r[24] ? 23'd0 : mant_r[22:0];

      if (raw == 28'd0)
         main_res = FP_ZERO;
      else if (exp_r <= 10'sd0)
         main_res = {big_s, 31'd0};
      else if (exp_r >= 10'sd255)
         main_res = {big_s, 8'hFF, 23'd0};
      else
         main_res = {big_s, exp_r[7:0], frac};

      if (a_spec || b_spec) begin
         if (is_nan)
            sum = FP_QNAN;
         else if (a_spec)
            sum = {sa, 8'hFF, 23'd0};
         else
            sum = {sb, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
         sum = {sa & sb, 31'd0};
      end else if (a_zero) begin
         sum = b;
      end else if (b_zero) begin
         sum = a;
      end else begin
         sum = main_res;
      end
   end

endmodule

// File: rtl/fp_accum_stream.sv
// ---------------------------------------------------------------------------
// fp_accum_stream
// Sums KERNEL_N consecutive valid FP32 products plus a per-group bias and
// emits the result with a one-cycle valid pulse.
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   s      : stream bundle (slave side): clear, bias, valid_in, data_in in;
//            sum_out, valid_out, busy out
// One shared combinational adder: operand A is the bias for the first product
// of a group (IDLE) and the running sum otherwise (ACCUM).
// ---------------------------------------------------------------------------
module fp_accum_stream
   import fp_accum_stream_pkg::*;
#(
   parameter int KERNEL_N = 9,
   parameter int CNT_W    = 8
) (
   input  logic                clk,
   input  logic                resetn,
   fp_accum_stream_if.slave    s
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_N - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [31:0]        acc_reg, acc_next;
   logic [31:0]        sum_out_reg, sum_out_next;
   logic               valid_out_reg, valid_out_next;

   logic [31:0]        op_a;
   logic [31:0]        add_res;

   assign op_a = (state_reg == IDLE) ? s.bias : acc_reg;

   fp_add32 u_add (
      .sum (add_res),
      .a   (op_a),
      .b   (s.data_in)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         acc_reg       <= FP_ZERO;
         sum_out_reg   <= FP_ZERO;
         valid_out_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         acc_reg       <= acc_next;
         sum_out_reg   <= sum_out_next;
         valid_out_reg <= valid_out_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      acc_next       = acc_reg;
      sum_out_next   = sum_out_reg;
      valid_out_next = 1'b0;

      if (s.clear) begin
         // Abort wins over a coincident product, including a final one.
         state_next = IDLE;
         cnt_next   = '0;
         acc_next   = FP_ZERO;
      end else if (s.valid_in) begin
         unique case (state_reg)
            IDLE: begin
               acc_next   = add_res;
               cnt_next   = CNT_W'(1);
               state_next = ACCUM;
            end
            ACCUM: begin
               if (cnt_reg == LAST_CNT) begin
                  sum_out_next   = add_res;
                  valid_out_next = 1'b1;
                  cnt_next       = '0;
                  acc_next       = FP_ZERO;
                  state_next     = IDLE;
               end else begin
                  acc_next = add_res;
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign s.sum_out   = sum_out_reg;
   assign s.valid_out = valid_out_reg;
   assign s.busy      = (state_reg == ACCUM);

endmodule

// File: tb/tb_fp_accum_stream.sv
// ---------------------------------------------------------------------------
// tb_fp_accum_stream
// Scoreboard bench: each group's expected sum and pulse cycle are queued when
// its final product is driven; a monitor pops them on every valid_out pulse.
// ---------------------------------------------------------------------------
module tb_fp_accum_stream;

   typedef struct {
      logic [31:0] val;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        resetn;
   int          cyc;
   int          n_checks;
   int          n_fail;
   int          pulses;
   int          last_pulse;
   int          prev_pulse;
   exp_t        q[$];

   fp_accum_stream_if bus ();

   fp_accum_stream #(
      .KERNEL_N (9),
      .CNT_W    (8)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .s      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: compare every pulse against the head of the scoreboard.
   always @(negedge clk) begin
      if (resetn && bus.valid_out) begin
         pulses++;
         prev_pulse = last_pulse;
         last_pulse = cyc;
         check_eq("pulse_pending", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check_eq("sum_out", bus.sum_out, e.val);
            check_eq("latency", 32'(cyc), 32'(e.cyc));
            $display("pulse %0d: sum_out=%h expected=%h cycle=%0d", pulses, bus.sum_out, e.val, cyc);
         end
      end
   end

   task automatic send(input logic [31:0] b, input logic [31:0] d);
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.bias     = b;
      bus.valid_in = 1'b1;
      bus.data_in  = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.clear    = 1'b0;
         bus.valid_in = 1'b0;
      end
   endtask

   // Nine identical products; the expected result is queued with the last one.
   task automatic run_const_group(input logic [31:0] b, input logic [31:0] d,
                                  input int gap, input logic [31:0] exp_sum,
                                  input bit chk_busy);
      for (int k = 0; k < 9; k++) begin
         send(b, d);
         if (k == 8) begin
            exp_t e;
            e.val = exp_sum;
            e.cyc = cyc + 1;
            q.push_back(e);
         end else begin
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               bus.valid_in = 1'b0;
               if (chk_busy && g == 0) check_eq("busy_gap", 32'(bus.busy), 32'd1);
            end
         end
      end
      if (chk_busy) begin
         @(negedge clk);
         bus.valid_in = 1'b0;
         check_eq("busy_end", 32'(bus.busy), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      pulses       = 0;
      last_pulse   = 0;
      prev_pulse   = 0;
      resetn       = 1'b0;
      bus.clear    = 1'b0;
      bus.bias     = 32'h0;
      bus.valid_in = 1'b0;
      bus.data_in  = 32'h0;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_sum", bus.sum_out, 32'h0);
      check_eq("rst_valid", 32'(bus.valid_out), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      resetn = 1'b1;

      // Reset mid-group after 4 products
      for (int k = 0; k < 4; k++) send(32'h0, 32'h3F80_0000);
      idle(1);
      check_eq("busy_mid", 32'(bus.busy), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check_eq("mid_rst_sum", bus.sum_out, 32'h0);
      check_eq("mid_rst_valid", 32'(bus.valid_out), 32'd0);
      check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      idle(1);
      check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
      run_const_group(32'h0, 32'h3F80_0000, 0, 32'h4110_0000, 1'b0);
      idle(3);

      // Basic group: 9 x 1.0, bias 0
      run_const_group(32'h0, 32'h3F80_0000, 0, 32'h4110_0000, 1'b0);
      idle(3);

      // Bias 0.5 with two-cycle gaps
      run_const_group(32'h3F00_0000, 32'h3F80_0000, 2, 32'h4118_0000, 1'b1);
      idle(3);

      // Back-to-back: 9 x 2.0 then 9 x -1.0 with no bubble
      run_const_group(32'h0, 32'h4000_0000, 0, 32'h4190_0000, 1'b0);
      run_const_group(32'h0, 32'hBF80_0000, 0, 32'hC110_0000, 1'b0);
      idle(3);
      check_eq("b2b_spacing", 32'(last_pulse - prev_pulse), 32'd9);

      // Clear abort with a coincident product
      for (int k = 0; k < 5; k++) send(32'h0, 32'h3F80_0000);
      @(negedge clk);
      bus.clear    = 1'b1;
      bus.valid_in = 1'b1;
      bus.data_in  = 32'h3F80_0000;
      idle(1);
      check_eq("clear_busy", 32'(bus.busy), 32'd0);
      check_eq("clear_hold", bus.sum_out, 32'hC110_0000);
      idle(2);
      run_const_group(32'h0, 32'h3F80_0000, 0, 32'h4110_0000, 1'b0);
      idle(3);

      // Cancellation: +1,-1 alternating, ninth +0.0
      for (int k = 0; k < 9; k++) begin
         if (k == 8) begin
            exp_t e;
            send(32'h0, 32'h0000_0000);
            e.val = 32'h0000_0000;
            e.cyc = cyc + 1;
            q.push_back(e);
         end else begin
            send(32'h0, (k % 2 == 0) ? 32'h3F80_0000 : 32'hBF80_0000);
         end
      end
      idle(4);

      check_eq("queue_empty", 32'(q.size()), 32'd0);
      check_eq("pulse_count", 32'(pulses), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_accum_stream.md
Name: fp_accum_stream

Overview:
- Downstream consumer of the valid-qualified FP32 product stream from the multiplier wrapper (out/valid_out pair).
- Sums KERNEL_N consecutive valid products plus a per-group bias into one FP32 partial sum.
- Emits the sum with a single-cycle valid pulse.
- Sits between the FP multiplier and the VGG16 convolution result path; one instance per MAC lane.

Parameters:
- KERNEL_N, 9, number of valid products summed per output (3x3 kernel); legal range 2..255.
- CNT_W, 8, width of the product counter; must satisfy 2^CNT_W > KERNEL_N.

Ports:
- clk  input  1  single system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort: drops the partial sum and restarts the group.
- bias  input  32  FP32 bias; sampled with the first product of each group.
- valid_in  input  1  data_in is a valid product this cycle.
- data_in  input  32  FP32 product (multiplier out).
- sum_out  output  32  FP32 accumulated result; holds its value between pulses.
- valid_out  output  1  one-cycle pulse; sum_out is valid this cycle.
- busy  output  1  high while a group is partially accumulated (state ACCUM).

Behaviour:
- One clock domain; resetn is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, acc=32'h0, sum_out=32'h0, valid_out=0, busy=0.
- Reset mid-group discards the partial sum, with no output pulse.
- States:
  - IDLE (cnt==0): on valid_in, acc <= fp_add(bias, data_in), cnt <= 1, go to ACCUM.
  - ACCUM: on valid_in with cnt < KERNEL_N-1, acc <= fp_add(acc, data_in), cnt <= cnt+1.
  - ACCUM: on valid_in with cnt == KERNEL_N-1, sum_out <= fp_add(acc, data_in), valid_out <= 1 next cycle, cnt <= 0, acc <= 0, go to IDLE.
- valid_in=0: all registers hold. Gaps of any length inside a group are legal.
- Latency: valid_out rises on the clock edge after the KERNEL_N-th valid_in is sampled, so it is visible 1 cycle later.
- valid_out is registered and high for exactly one cycle.
- Back-to-back groups: a valid_in in the cycle right after the last product of a group starts the next group. No bubble is required; full throughput is 1 product/cycle.
- clear has priority over valid_in. With clear=1: cnt <= 0, acc <= 0, state <= IDLE, and that cycle's data_in is dropped.
- If clear coincides with a final product, that group produces no valid_out. A valid_out already registered still fires.
- busy = (state == ACCUM), registered.
- Arithmetic:
  - IEEE-754 single precision, round-to-nearest-even as implemented by the shared FP adder.
  - Denormals flush to zero.
  - No exception flags.
  - +0 + -0 yields +0.
- The adder is combinational; acc and sum_out are its only registers. No extra pipeline stage in this block.

Decomposition:
- Shared package/header holds:
  - FP32 constants: FP_ZERO = 32'h00000000, FP_ONE = 32'h3F800000.
  - State encodings: IDLE = 1'b0, ACCUM = 1'b1.
- One sub-module: fp_add32 (combinational FP32 adder, ports sum, a, b), the additive counterpart of the existing FP multiplier. It is instantiated once, with operand A muxed between bias (IDLE) and acc (ACCUM).
- Target size: fp_accum_stream about 120 lines; fp_add32 about 200 lines.

Test Plan:
- Reset check: assert resetn=0 mid-group after 4 valid products, then release -> sum_out=0, valid_out=0, busy=0; a fresh 9-product group then sums correctly.
- Basic group: bias=32'h00000000, 9 consecutive valid_in with data_in=32'h3F800000 (1.0) -> one valid_out pulse 1 cycle after the 9th input, sum_out=32'h41100000 (9.0).
- Bias and gaps: bias=32'h3F000000 (0.5), 9 products of 1.0 with 2-cycle valid_in gaps between each -> sum_out=32'h41180000 (9.5); busy high from the 1st product through the 9th.
- Back-to-back groups:
  - Group A: 18 contiguous products, first 9 = 2.0 (32'h40000000), bias 0 -> first pulse sum_out=32'h41900000 (18.0).
  - Group B: next 9 = -1.0 (32'hBF800000) -> second pulse exactly 9 cycles later, sum_out=32'hC1100000 (-9.0).
- Clear abort: 5 products of 1.0, then clear=1 together with valid_in=1 -> no valid_out, busy=0. A following 9 x 1.0 group gives 32'h41100000.
- Cancellation: bias 0; products +1.0, -1.0 alternating, with a ninth of +0.0 -> sum_out=32'h00000000, valid_out pulses once.
